// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/redirect controller.
// No logic; widths and encodings only.
// Imported by stall_encode and stall_ctrl.
package stall_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int ADDR_W  = 32;
    localparam int WDOG_W  = 8;

    typedef logic [STALL_W-1:0] stall_bus_t;
    typedef logic [ADDR_W-1:0]  inst_addr_t;
    typedef logic [WDOG_W-1:0]  wdog_cnt_t;

    localparam logic       STOP      = 1'b1;
    localparam logic       NO_STOP   = 1'b0;
    localparam inst_addr_t ZERO_WORD = '0;
    localparam wdog_cnt_t  WDOG_MAX  = '1;

    // Bit positions inside the stall bus
    localparam int PC_BIT     = 0;
    localparam int EX_MEM_BIT = 3;

    // Freeze patterns: every stage at or before the requester stops
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/stall_encode.sv
// Priority encoder from per-stage stall requests to the freeze bus.
// Latency: combinational, zero cycles.
// Backpressure: none; the deepest requesting stage wins.
module stall_encode
    import stall_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    output stall_bus_t stall
);

    // Deepest stage wins so frozen bits are always a contiguous low-order run
    always_comb begin
        stall = STALL_NONE;
        if (stallreq_mem)     stall = STALL_MEM;
        else if (stallreq_ex) stall = STALL_EX;
        else if (stallreq_id) stall = STALL_ID;
        else if (stallreq_if) stall = STALL_IF;
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall bus, branch redirect/flush sequencing and frozen-PC watchdog.
// Latency: stall and unblocked redirects are combinational; blocked redirects wait in PEND.
// Backpressure: branches seen while EX/MEM is frozen are dropped; EX re-presents them.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 255
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    input  logic       branch_flag,
    input  inst_addr_t branch_target,
    output stall_bus_t stall,
    output logic       flush,
    output logic       new_pc_valid,
    output inst_addr_t new_pc,
    output logic       stall_err
);

    localparam wdog_cnt_t LIMIT = wdog_cnt_t'(WDOG_LIMIT);

    stall_bus_t stall_raw;
    state_t     state;
    state_t     state_nxt;
    inst_addr_t pend_pc;
    inst_addr_t pend_pc_nxt;
    wdog_cnt_t  wdog_cnt;
    wdog_cnt_t  wdog_nxt;
    logic       pc_stop;
    logic       ex_stop;
    logic       br_acc;

    stall_encode u_encode (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .stall        (stall_raw)
    );

    // Outputs go quiet while reset is held, whatever the requests say
    assign stall   = rst ? stall_raw : STALL_NONE;
    assign pc_stop = (stall[PC_BIT] == STOP);
    assign ex_stop = (stall[EX_MEM_BIT] == STOP);
    assign br_acc  = branch_flag && !ex_stop;

    // Redirect decision: immediate when the PC can load, otherwise parked in PEND
    always_comb begin
        flush        = 1'b0;
        new_pc_valid = 1'b0;
        new_pc       = ZERO_WORD;
        state_nxt    = state;
        pend_pc_nxt  = pend_pc;
        if (rst) begin
            case (state)
                RUN: begin
                    if (br_acc) begin
                        if (!pc_stop) begin
                            flush        = 1'b1;
                            new_pc_valid = 1'b1;
                            new_pc       = branch_target;
                        end else begin
                            pend_pc_nxt = branch_target;
                            state_nxt   = PEND;
                        end
                    end
                end
                PEND: begin
                    // EX only holds a bubble here, so branch_flag is not looked at
                    if (!pc_stop) begin
                        flush        = 1'b1;
                        new_pc_valid = 1'b1;
                        new_pc       = pend_pc;
                        state_nxt    = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Watchdog counts consecutive frozen-PC cycles and saturates
    always_comb begin
        wdog_nxt = '0;
        if (pc_stop) begin
            wdog_nxt = (wdog_cnt == WDOG_MAX) ? WDOG_MAX : wdog_cnt + wdog_cnt_t'(1);
        end
    end

    // FSM state, parked target, watchdog count and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            pend_pc   <= ZERO_WORD;
            wdog_cnt  <= '0;
            stall_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_pc  <= pend_pc_nxt;
            wdog_cnt <= wdog_nxt;
            if (wdog_nxt == LIMIT) begin
                stall_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus a randomized run.
// Latency: outputs sampled at the falling edge, model state advanced at the rising edge.
// Backpressure: not applicable; the bench drives requests freely.
module tb_stall_ctrl;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_if = 1'b0, s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0, br = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [5:0]  stall;
    logic        flush, npv, err;
    logic [31:0] npc;

    stall_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (s_if),
        .stallreq_id   (s_id),
        .stallreq_ex   (s_ex),
        .stallreq_mem  (s_mem),
        .branch_flag   (br),
        .branch_target (tgt),
        .stall         (stall),
        .flush         (flush),
        .new_pc_valid  (npv),
        .new_pc        (npc),
        .stall_err     (err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: committed state
    bit          m_pend;
    logic [31:0] m_pend_addr;
    int          m_run;
    bit          m_err;
    // Reference model: expectations for the cycle being driven, and next state
    logic [5:0]  e_stall;
    bit          e_flush, e_npv;
    logic [31:0] e_npc;
    bit          n_pend;
    logic [31:0] n_pend_addr;
    int          n_run;
    bit          n_err;

    function automatic logic [40:0] obs();
        return {stall, flush, npv, npc, err};
    endfunction

    function automatic logic [40:0] expv();
        return {e_stall, e_flush, e_npv, e_npc, m_err};
    endfunction

    function automatic void model_reset();
        m_pend = 0; m_pend_addr = 32'h0; m_run = 0; m_err = 0;
    endfunction

    // Apply one cycle of inputs (called just after a rising edge), compute the
    // expected outputs from the rules, then wait for the falling edge to sample.
    task automatic drive(input bit a_if, a_id, a_ex, a_mem, a_br, input logic [31:0] a_tgt);
        int depth;
        bit pc_frozen, ex_frozen;
        s_if = a_if; s_id = a_id; s_ex = a_ex; s_mem = a_mem; br = a_br; tgt = a_tgt;
        depth     = a_mem ? 5 : a_ex ? 4 : a_id ? 3 : a_if ? 2 : 0;
        e_stall   = 6'((1 << depth) - 1);
        pc_frozen = depth > 0;
        ex_frozen = depth >= 4;
        e_flush = 0; e_npv = 0; e_npc = 32'h0;
        n_pend = m_pend; n_pend_addr = m_pend_addr;
        if (!m_pend) begin
            if (a_br && !ex_frozen) begin
                if (!pc_frozen) begin
                    e_flush = 1; e_npv = 1; e_npc = a_tgt;
                end else begin
                    n_pend = 1; n_pend_addr = a_tgt;
                end
            end
        end else if (!pc_frozen) begin
            e_flush = 1; e_npv = 1; e_npc = m_pend_addr;
            n_pend = 0;
        end
        n_run = pc_frozen ? m_run + 1 : 0;
        n_err = m_err || (n_run >= LIMIT);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        m_pend = n_pend; m_pend_addr = n_pend_addr; m_run = n_run; m_err = n_err;
        #1;
    endtask

    // Hold reset for two cycles with random requests, checking the quiet outputs
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            s_if = 1'($urandom); s_id = 1'($urandom); s_ex = 1'($urandom);
            s_mem = 1'($urandom); br = 1'b1; tgt = $urandom;
            @(negedge clk);
            vectors++;
            if (obs() !== 41'h0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h expected %h", obs(), 41'h0);
            end
            @(posedge clk);
            #1;
        end
        s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; br = 0; tgt = 32'h0;
        rst = 1'b1;
    endtask

    task automatic test_priority();
        drive(0, 1, 0, 1, 0, 32'h0);
        vectors++;
        if (stall !== 6'b011111 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL prio_mem_id: stall got %b expected %b", stall, 6'b011111);
        end
        tick();
        drive(0, 1, 0, 0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b000111 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL prio_id_only: stall got %b expected %b", stall, 6'b000111);
        end
        tick();
        drive(1, 0, 1, 0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b001111) begin
            miscompares++;
            $display("FAIL prio_ex_if: stall got %b expected %b", stall, 6'b001111);
        end
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        vectors++;
        if (stall !== 6'b000011) begin
            miscompares++;
            $display("FAIL prio_if_only: stall got %b expected %b", stall, 6'b000011);
        end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
    endtask

    task automatic test_branch_immediate();
        test_reset();
        drive(0, 0, 0, 0, 1, 32'h0000_1040);
        vectors++;
        if ({flush, npv, npc} !== {1'b1, 1'b1, 32'h0000_1040}) begin
            miscompares++;
            $display("FAIL br_immediate: got f=%b v=%b pc=%h expected f=1 v=1 pc=00001040", flush, npv, npc);
        end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0000_1040);
        vectors++;
        if ({stall, flush, npv, npc} !== 40'h0) begin
            miscompares++;
            $display("FAIL br_after_idle: got %h expected 0", {stall, flush, npv, npc});
        end
        tick();
    endtask

    task automatic test_branch_deferred();
        test_reset();
        for (int c = 1; c <= 4; c++) begin
            drive(0, c <= 3, 0, 0, c == 1, (c == 1) ? 32'h0000_2000 : 32'hDEAD_BEEF);
            vectors++;
            if (c <= 3) begin
                if (flush !== 1'b0 || npv !== 1'b0 || npc !== 32'h0) begin
                    miscompares++;
                    $display("FAIL br_deferred_wait c%0d: got f=%b v=%b pc=%h expected idle", c, flush, npv, npc);
                end
            end else if ({flush, npv, npc} !== {1'b1, 1'b1, 32'h0000_2000}) begin
                miscompares++;
                $display("FAIL br_deferred_fire: got f=%b v=%b pc=%h expected f=1 v=1 pc=00002000", flush, npv, npc);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 32'h0);
        vectors++;
        if (flush !== 1'b0 || npv !== 1'b0) begin
            miscompares++;
            $display("FAIL br_deferred_once: got f=%b v=%b expected 0 0", flush, npv);
        end
        tick();
    endtask

    task automatic test_branch_held();
        int redirects;
        test_reset();
        redirects = 0;
        for (int c = 1; c <= 4; c++) begin
            drive(0, 0, 0, c <= 3, 1, 32'h0000_3000);
            if (npv === 1'b1) redirects++;
            vectors++;
            if (npv !== (c == 4) || flush !== (c == 4)) begin
                miscompares++;
                $display("FAIL br_held c%0d: got v=%b f=%b expected %b", c, npv, flush, c == 4);
            end
            tick();
        end
        vectors++;
        if (redirects != 1) begin
            miscompares++;
            $display("FAIL br_held_count: got %0d expected 1", redirects);
        end
    endtask

    task automatic test_watchdog();
        test_reset();
        for (int c = 1; c <= 4; c++) begin
            drive(1, 0, 0, 0, 0, 32'h0);
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL wdog_early c%0d: got %b expected 0", c, err);
            end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 0, 32'h0);
            vectors++;
            if (err !== 1'b1) begin
                miscompares++;
                $display("FAIL wdog_sticky c%0d: got %b expected 1", c, err);
            end
            tick();
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL wdog_reset_clear: got %b expected 0", err);
        end
        test_reset();
    endtask

    task automatic test_reset_in_pend();
        test_reset();
        drive(0, 1, 0, 0, 1, 32'h0000_5000);
        tick();
        drive(0, 1, 0, 0, 0, 32'h0);
        tick();
        test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 32'h0);
            vectors++;
            if (flush !== 1'b0 || npv !== 1'b0 || npc !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_in_pend c%0d: got f=%b v=%b pc=%h expected idle", c, flush, npv, npc);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(63) == 0) test_reset();
            drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(5) == 0,
                  $urandom_range(6) == 0, $urandom_range(2) == 0, $urandom);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h expected %h", c, obs(), expv());
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_priority();
        test_branch_immediate();
        test_branch_deferred();
        test_branch_held();
        test_watchdog();
        test_reset_in_pend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter: WDOG_LIMIT, default 255, consecutive frozen-PC cycles before stall_err sets; range 1..255.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 stallreq_if  input  1  IF stage waiting on instruction memory.
REQ-005 stallreq_id  input  1  ID load-use hazard.
REQ-006 stallreq_ex  input  1  EX multi-cycle operation in progress.
REQ-007 stallreq_mem  input  1  MEM stage waiting on data memory.
REQ-008 branch_flag  input  1  EX resolved a taken branch/jump this cycle.
REQ-009 branch_target  input  32  redirect address accompanying branch_flag.
REQ-010 stall  output  6 (StallBus)  per-stage freeze: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB; Stop = 1.
REQ-011 flush  output  1  kill contents of if_id and id_ex registers this edge.
REQ-012 new_pc_valid  output  1  PC loads new_pc this edge.
REQ-013 new_pc  output  32  redirect address; ZeroWord when new_pc_valid = 0.
REQ-014 stall_err  output  1  sticky watchdog flag.

Function
REQ-015 stall is combinational from current requests, deepest requester wins: mem -> 011111, else ex -> 001111, else id -> 000111, else if -> 000011, else 000000.
REQ-016 Consumer rule: a stage register inserts a bubble when stall[i] = Stop and stall[i+1] = NoStop; encodings in REQ-015 guarantee contiguous low-order Stop bits.
REQ-017 FSM states RUN and PEND; reset state RUN.
REQ-018 Branch accepted only in a cycle with branch_flag = 1 and stall[3] = NoStop; branch_flag while stall[3] = Stop is ignored (EX re-presents it).
REQ-019 RUN, accepted branch, stall[0] = NoStop: flush = 1, new_pc_valid = 1, new_pc = branch_target, same cycle (zero latency); stay RUN.
REQ-020 RUN, accepted branch, stall[0] = Stop: register branch_target into pend_pc, flush = 0, new_pc_valid = 0, go PEND.
REQ-021 PEND, stall[0] = Stop: outputs idle, hold pend_pc.
REQ-022 PEND, stall[0] = NoStop: flush = 1, new_pc_valid = 1, new_pc = pend_pc; go RUN.
REQ-023 PEND ignores branch_flag (EX holds a bubble from flush/stall; a second taken branch in PEND is impossible).
REQ-024 Watchdog: 8-bit wdog_cnt increments each cycle stall[0] = Stop, clears to 0 when stall[0] = NoStop, saturates at 255.
REQ-025 stall_err sets on the edge where wdog_cnt reaches WDOG_LIMIT; cleared only by reset.
REQ-026 Reset mid-PEND discards pend_pc; no redirect issued after release.

Reset
REQ-027 On rst = 0, immediately: state RUN, pend_pc = ZeroWord, wdog_cnt = 0, stall_err = 0.
REQ-028 Combinational outputs during reset: stall = 000000, flush = 0, new_pc_valid = 0, new_pc = ZeroWord, regardless of inputs.

Structure
REQ-029 StallBus, Stop/NoStop, InstAddrBus, ZeroWord and the RUN/PEND encodings live in defines.vh; no local width literals.
REQ-030 One sub-module, stall_encode (pure combinational REQ-015 priority encoder); FSM, pend_pc and watchdog stay in stall_ctrl.

Verification
REQ-031 stallreq_mem = 1 and stallreq_id = 1 together -> stall = 011111; drop mem -> 000111 same cycle.
REQ-032 branch_flag = 1, target 0x00001040, no requests -> flush = 1, new_pc_valid = 1, new_pc = 0x00001040 that cycle; next cycle all idle.
REQ-033 stallreq_id = 1 for 3 cycles with branch_flag pulsed in cycle 1, target 0x2000 -> no redirect cycles 1-3; cycle 4 flush = 1, new_pc = 0x2000.
REQ-034 branch_flag held 4 cycles with stallreq_mem = 1 for first 3 -> exactly one redirect, in cycle 4.
REQ-035 WDOG_LIMIT = 4, stallreq_if = 1 for 4 cycles -> stall_err rises after 4th edge, stays 1 after request drops; rst = 0 clears it.
REQ-036 Reset asserted while PEND, release with no requests -> no flush, no new_pc_valid.
